// File: rtl/cpuc_package.sv
// Shared CPUC definitions: datapath widths, the register-bank geometry, the
// write-arbiter state type and the enabled async-reset flop macro.

`ifndef CPUC_DFF_EN
`define CPUC_DFF_EN(q, d, en, clk, rst) \
  always_ff @(posedge clk or posedge rst) \
    if (rst) q <= '0; \
    else if (en) q <= d;
`endif

package cpuc_package;

  localparam int DATA_WIDTH       = 32;
  localparam int DEFAULT_NUM_REGS = 8;
  localparam int REG_ADDR_W       = $clog2(DEFAULT_NUM_REGS);

  typedef enum logic [1:0] {
    RWA_IDLE,
    RWA_CLEAR,
    RWA_DONE
  } t_rwa_state;

endpackage

// File: rtl/cpuc_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer (wrapping) and moves the pointer just past the winner.

module cpuc_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic             found;
  int               gnt_idx;
  int               idx;

  // Search upward from the pointer with wrap; the first active request wins.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    gnt_idx = 0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  // A grant is always a handshake (gnt only follows req), so advance on any grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == NUM_REQ - 1) ? '0 : PTR_W'(gnt_idx + 1);
    end
  end

endmodule

// File: rtl/cpuc_reg_write_arbiter.sv
// Register bank with a single shared write port: round-robin arbitration
// among requesters, a sequenced whole-bank clear and a combinational read port.

module cpuc_reg_write_arbiter
  import cpuc_package::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                clear_start,
  output logic                                clear_busy,
  output logic                                clear_done,
  input  logic [REG_ADDR_W-1:0]               rd_addr,
  output logic [DATA_WIDTH-1:0]               rd_data
);

  t_rwa_state              state;
  t_rwa_state              state_next;
  logic [REG_ADDR_W-1:0]   clr_cnt;
  logic [REG_ADDR_W-1:0]   clr_cnt_next;
  logic                    arb_en;
  logic                    clr_we;
  logic [NUM_REQ-1:0]      gnt;
  logic                    wr_en;
  logic [REG_ADDR_W-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   bank [NUM_REGS];

  cpuc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  // FSM state and clear counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RWA_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next state and status: clear_start wins over requesters in IDLE; the
  // arbiter is held off during reset so no grant is shown while rst is high.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    arb_en       = 1'b0;
    clr_we       = 1'b0;
    clear_busy   = 1'b0;
    clear_done   = 1'b0;
    case (state)
      RWA_IDLE: begin
        if (clear_start) begin
          state_next   = RWA_CLEAR;
          clr_cnt_next = '0;
        end else begin
          arb_en = !rst;
        end
      end
      RWA_CLEAR: begin
        clear_busy   = 1'b1;
        clr_we       = 1'b1;
        clr_cnt_next = clr_cnt + REG_ADDR_W'(1);
        if (clr_cnt == REG_ADDR_W'(NUM_REGS - 1)) begin
          state_next = RWA_DONE;
        end
      end
      RWA_DONE: begin
        clear_done = 1'b1;
        state_next = RWA_IDLE;
      end
      default: begin
        state_next = RWA_IDLE;
      end
    endcase
  end

  // Single write port: the granted requester, or the clear sweep writing zero.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wr_en   = 1'b1;
        wr_addr = req_addr[i];
        wr_data = req_data[i];
      end
    end
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = '0;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_bank
    logic [DATA_WIDTH-1:0] q;
    // One enabled async-reset storage flop per register.
    `CPUC_DFF_EN(q, wr_data, (wr_en && (wr_addr == REG_ADDR_W'(r))), clk, rst)
    assign bank[r] = q;
  end

  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_cpuc_reg_write_arbiter.sv
// Self-checking bench for cpuc_reg_write_arbiter: reset checks, a vector
// table, hand-written clear/reset sequences and a randomized run against a
// behavioural model of the bank.

module tb_cpuc_reg_write_arbiter;

  localparam int N  = 3;
  localparam int R  = 8;
  localparam int AW = 3;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_ready;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   clear_done;
  logic [AW-1:0]          rd_addr;
  logic [DW-1:0]          rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: bank contents, rr pointer, clear progress.
  logic [DW-1:0] m_bank [R];
  int            m_ptr;
  bit            m_clearing;
  int            m_cidx;
  bit            m_done;

  typedef struct {
    logic [N-1:0]         valid;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] data;
    logic [AW-1:0]        rd;
    logic [N-1:0]         exp_ready;
    logic [DW-1:0]        exp_rd;
  } vec_t;

  vec_t vecs [11];

  cpuc_reg_write_arbiter #(
    .NUM_REQ  (N),
    .NUM_REGS (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                               input logic [N-1:0][DW-1:0] d, input logic cs, input logic [AW-1:0] ra);
    req_valid   = v;
    req_addr    = a;
    req_data    = d;
    clear_start = cs;
    rd_addr     = ra;
  endtask

  task automatic model_reset();
    for (int r = 0; r < R; r++) m_bank[r] = '0;
    m_ptr      = 0;
    m_clearing = 1'b0;
    m_cidx     = 0;
    m_done     = 1'b0;
  endtask

  function automatic logic [N-1:0] model_ready();
    if (rst || m_clearing || m_done || clear_start) return '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return N'(1 << i);
    end
    return '0;
  endfunction

  task automatic model_advance();
    logic [N-1:0] g;
    if (m_clearing) begin
      m_bank[m_cidx] = '0;
      m_cidx++;
      if (m_cidx == R) begin
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (clear_start) begin
      m_clearing = 1'b1;
      m_cidx     = 0;
    end else begin
      g = model_ready();
      for (int k = 0; k < N; k++) begin
        if (g[k]) begin
          m_bank[req_addr[k]] = req_data[k];
          m_ptr = (k + 1) % N;
        end
      end
    end
  endtask

  task automatic run_cycle(input string tag);
    #2;
    checkOutput({tag, ".ready"}, DW'(req_ready), DW'(model_ready()));
    checkOutput({tag, ".busy"}, DW'(clear_busy), DW'(m_clearing));
    checkOutput({tag, ".done"}, DW'(clear_done), DW'(m_done));
    checkOutput({tag, ".rd_data"}, rd_data, m_bank[rd_addr]);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b0, '0);
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{3'b111, {3'd2, 3'd1, 3'd0}, {32'hC, 32'hB, 32'hA}, 3'd0, 3'b001, 32'h0};
    vecs[1]  = '{3'b111, {3'd2, 3'd1, 3'd0}, {32'hC, 32'hB, 32'hA}, 3'd0, 3'b010, 32'hA};
    vecs[2]  = '{3'b111, {3'd2, 3'd1, 3'd0}, {32'hC, 32'hB, 32'hA}, 3'd1, 3'b100, 32'hB};
    vecs[3]  = '{3'b111, {3'd2, 3'd1, 3'd0}, {32'hC, 32'hB, 32'hA}, 3'd2, 3'b001, 32'hC};
    vecs[4]  = '{3'b000, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h0}, 3'd0, 3'b000, 32'hA};
    vecs[5]  = '{3'b010, {3'd0, 3'd3, 3'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'd3, 3'b010, 32'h0};
    vecs[6]  = '{3'b000, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h0}, 3'd3, 3'b000, 32'hDEADBEEF};
    vecs[7]  = '{3'b100, {3'd4, 3'd0, 3'd0}, {32'h22, 32'h0, 32'h0}, 3'd4, 3'b100, 32'h0};
    vecs[8]  = '{3'b101, {3'd6, 3'd0, 3'd5}, {32'h26, 32'h0, 32'h10}, 3'd4, 3'b001, 32'h22};
    vecs[9]  = '{3'b101, {3'd6, 3'd0, 3'd5}, {32'h26, 32'h0, 32'h10}, 3'd5, 3'b100, 32'h10};
    vecs[10] = '{3'b000, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h0}, 3'd6, 3'b000, 32'h26};

    // Reset state: bank reads zero, no grant even with every requester valid.
    rst = 1'b1;
    applyStimulus(3'b111, '0, '0, 1'b0, '0);
    model_reset();
    #2;
    checkOutput("rst.ready", DW'(req_ready), '0);
    checkOutput("rst.busy", DW'(clear_busy), '0);
    checkOutput("rst.done", DW'(clear_done), '0);
    for (int a = 0; a < R; a++) begin
      rd_addr = AW'(a);
      #1;
      checkOutput($sformatf("rst.rd%0d", a), rd_data, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b0, '0);

    // Vector table: round-robin rotation, single requester, pointer wrap.
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].addr, vecs[v].data, 1'b0, vecs[v].rd);
      #2;
      checkOutput($sformatf("vec%0d.ready", v), DW'(req_ready), DW'(vecs[v].exp_ready));
      checkOutput($sformatf("vec%0d.rd_data", v), rd_data, vecs[v].exp_rd);
      checkOutput($sformatf("vec%0d.busy", v), DW'(clear_busy), '0);
      model_advance();
      @(posedge clk);
      #1;
    end

    // Clear sequence: preload 0x55, clear_start with req 0 pending.
    do_reset();
    for (int r = 0; r < R; r++) begin
      applyStimulus(3'b001, {3'd0, 3'd0, AW'(r)}, {32'h0, 32'h0, 32'h55}, 1'b0, AW'(r));
      run_cycle("preload");
    end
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd1}, {32'h0, 32'h0, 32'h77}, 1'b1, 3'd1);
    #2;
    checkOutput("clr.start.ready", DW'(req_ready), '0);
    checkOutput("clr.start.busy", DW'(clear_busy), '0);
    checkOutput("clr.start.rd", rd_data, 32'h55);
    model_advance();
    @(posedge clk);
    #1;
    for (int c = 1; c <= R; c++) begin
      clear_start = (c == 1);
      rd_addr     = AW'(c - 1);
      #2;
      checkOutput($sformatf("clr.c%0d.busy", c), DW'(clear_busy), 32'h1);
      checkOutput($sformatf("clr.c%0d.done", c), DW'(clear_done), '0);
      checkOutput($sformatf("clr.c%0d.ready", c), DW'(req_ready), '0);
      checkOutput($sformatf("clr.c%0d.rd", c), rd_data, 32'h55);
      model_advance();
      @(posedge clk);
      #1;
    end
    clear_start = 1'b1;
    rd_addr     = 3'd7;
    #2;
    checkOutput("clr.c9.done", DW'(clear_done), 32'h1);
    checkOutput("clr.c9.busy", DW'(clear_busy), '0);
    checkOutput("clr.c9.ready", DW'(req_ready), '0);
    checkOutput("clr.c9.rd", rd_data, '0);
    model_advance();
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    rd_addr     = 3'd1;
    #2;
    checkOutput("clr.c10.ready", DW'(req_ready), 32'h1);
    checkOutput("clr.c10.done", DW'(clear_done), '0);
    checkOutput("clr.c10.rd", rd_data, '0);
    model_advance();
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int a = 0; a < R; a++) begin
      rd_addr = AW'(a);
      #1;
      checkOutput($sformatf("clr.after.rd%0d", a), rd_data, (a == 1) ? 32'h77 : 32'h0);
    end

    // Reset in the 4th clear cycle: outputs drop at once, no done pulse.
    do_reset();
    applyStimulus(3'b100, {3'd7, 3'd0, 3'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, 3'd7);
    run_cycle("rstclr.pre");
    applyStimulus('0, '0, '0, 1'b1, 3'd7);
    run_cycle("rstclr.start");
    clear_start = 1'b0;
    run_cycle("rstclr.c1");
    run_cycle("rstclr.c2");
    run_cycle("rstclr.c3");
    #1;
    checkOutput("rstclr.c4.busy", DW'(clear_busy), 32'h1);
    checkOutput("rstclr.c4.rd", rd_data, 32'h99);
    req_valid = 3'b111;
    rst       = 1'b1;
    #1;
    checkOutput("rstclr.async.busy", DW'(clear_busy), '0);
    checkOutput("rstclr.async.done", DW'(clear_done), '0);
    checkOutput("rstclr.async.ready", DW'(req_ready), '0);
    checkOutput("rstclr.async.rd", rd_data, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    run_cycle("rstclr.idle1");
    run_cycle("rstclr.idle2");
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd7}, {32'h0, 32'h0, 32'h1234}, 1'b0, 3'd7);
    run_cycle("rstclr.wr");
    req_valid = '0;
    #2;
    checkOutput("rstclr.readback", rd_data, 32'h1234);
    run_cycle("rstclr.rd");

    // Randomized traffic against the model, with occasional clears.
    do_reset();
    repeat (400) begin
      logic [N-1:0][AW-1:0] ra;
      logic [N-1:0][DW-1:0] rdat;
      for (int k = 0; k < N; k++) begin
        ra[k]   = AW'($urandom_range(0, R - 1));
        rdat[k] = $urandom;
      end
      applyStimulus(N'($urandom_range(0, 7)), ra, rdat,
                    ($urandom_range(0, 15) == 0), AW'($urandom_range(0, R - 1)));
      run_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpuc_reg_write_arbiter.md
Name: cpuc_reg_write_arbiter

Overview:
- Owns a bank of NUM_REGS data registers and shares their single write port among NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake.
- Provides a sequenced bank-clear operation and one combinational read port.
- Sits between the CPUC execution/load units and the register storage; it is the only agent that writes the bank.

Parameters:
- NUM_REQ, 3, number of write requesters (>=2).
- NUM_REGS, 8, number of DATA_WIDTH registers in the bank (power of 2, >=2).
- DATA_WIDTH comes from cpuc_package (32). REG_ADDR_W = $clog2(NUM_REGS), also from the package.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ x REG_ADDR_W  per-requester target register.
- req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_ready  output  NUM_REQ  one-hot grant; a write happens on a clk edge where valid[i]&ready[i].
- clear_start  input  1  pulse: zero the entire bank.
- clear_busy  output  1  high while a clear is in progress.
- clear_done  output  1  one-cycle pulse when a clear completes.
- rd_addr  input  REG_ADDR_W  read address.
- rd_data  output  DATA_WIDTH  contents of the addressed register.

Behaviour:
- Reset (async, rst=1):
  - All registers = 0; state = IDLE; rr pointer = 0; clear counter = 0.
  - clear_busy = 0, clear_done = 0, req_ready = 0, rd_data = 0.
- Storage: each register is an async-reset DFF with a write enable. rd_data is combinational from the registers, so a write at edge N is visible on rd_data after edge N. There is no write-to-read bypass in the same cycle.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - req_ready is combinational: the first i with req_valid[i]=1, searching from the rr pointer upward with wrap.
  - At most one ready bit is high; none is high if there are no valid requests.
  - On a handshake, reg[req_addr[i]] <= req_data[i] and the rr pointer <= (i+1) mod NUM_REQ.
  - The pointer holds when there is no grant.
  - req_ready depends on req_valid. Requesters must not derive valid from ready.
- IDLE & clear_start=1:
  - clear_start has priority. req_ready = 0 that cycle and no write occurs.
  - Next state = CLEAR, counter = 0.
- CLEAR:
  - clear_busy = 1 and req_ready = 0.
  - Each cycle, reg[counter] <= 0 and counter++.
  - When counter = NUM_REGS-1, the write happens and next state = DONE.
  - The clear takes exactly NUM_REGS cycles. clear_start is ignored while in CLEAR.
- DONE:
  - clear_done = 1 for exactly one cycle. clear_busy = 0; req_ready = 0.
  - Next state = IDLE. clear_start in DONE is ignored.
  - The rr pointer is unchanged across a clear.
- Requester fairness: a requester holding valid high is granted within NUM_REQ IDLE cycles.
- Address collisions cannot occur, because there is only one write per cycle.
- Out-of-range addresses are impossible by width.
- Reset asserted mid-CLEAR: the bank is zeroed immediately and the FSM returns to IDLE. No clear_done pulse is produced.
- rd_addr is sampled combinationally in all states, including CLEAR.

Decomposition:
- cpuc_package holds:
  - DATA_WIDTH (existing);
  - NUM_REGS default and REG_ADDR_W;
  - typedef enum logic [1:0] t_rwa_state {RWA_IDLE, RWA_CLEAR, RWA_DONE}.
- Sub-module cpuc_rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: clk, rst, req[NUM_REQ], en.
  - Output: one-hot gnt.
  - Owns the rr pointer, which advances only on a granted handshake.
- Storage flops use the codebase async-reset DFF macro with an enable.

Test Plan:
1. Reset, then read all 8 addresses -> rd_data = 0 for every address; req_ready = 0; clear_busy = 0.
2. Requester 1 alone: valid, addr=3, data=0xDEADBEEF -> req_ready = 3'b010 the same cycle; after the edge, rd_addr=3 gives 0xDEADBEEF.
3. All three requesters valid continuously, writing addrs 0/1/2 with data 0xA/0xB/0xC -> grants 001, 010, 100, 001 on consecutive cycles; reg0..2 = 0xA/0xB/0xC.
4. Preload regs with 0x55, then clear_start together with req_valid[0] -> no grant that cycle; clear_busy high for 8 cycles; clear_done pulses in cycle 9; all regs = 0; req_valid[0] is granted in cycle 10.
5. Assert rst in the 4th cycle of a clear -> all outputs 0 immediately; no clear_done; FSM in IDLE; a subsequent write to addr 7 = 0x1234 reads back 0x1234.
6. Requester 2 granted, then requesters 0 and 2 valid -> requester 0 is granted next (the pointer wrapped to 0), and requester 2 the cycle after.
